// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//
// Shares one single-ported unified instruction/data memory between the fetch
// stage and the memory stage. One memory transaction is in flight at a time.
// The data side wins contention, but once MAX_DATA_STREAK data grants have been
// given while fetch was waiting, fetch is granted next. A transaction that gets
// no mem_ack within TIMEOUT_CYCLES is abandoned: the requester is still released
// (fetch gets a NOP, data gets 0) and the sticky bus_error flag is raised.
//
// Handshakes: a requester raises *_req with stable address/data and holds it
// until its *_ready pulses for exactly one cycle. Changes made while the request
// is in flight are not observed. mem_req is held with stable mem_* outputs until
// the cycle in which mem_ack is high; mem_ack outside a transaction is ignored.
//
// Ports:
//   clk, rst           clock; synchronous active-high reset
//   ifetch_req/addr    fetch request and word address
//   ifetch_flush       pulse: the fetch in flight is stale, do not deliver it
//   ifetch_ready/rdata one-cycle delivery pulse and instruction word
//   dmem_req/we/addr/wdata/be  load/store request from the memory stage
//   dmem_ready/rdata   one-cycle completion pulse and load data (0 for stores)
//   mem_req/we/addr/wdata/be   external memory request (be = 4'hF on reads)
//   mem_ack/rdata      memory completion and read data
//   bus_error          sticky, set by a timeout, cleared only by rst
//   busy               arbiter is not idle
//   dbg_state          FSM state: 0 idle, 1 fetch wait, 2 data wait, 3 response

module mem_port_arbiter #(
  parameter int MAX_DATA_STREAK = 4,
  parameter int TIMEOUT_CYCLES  = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ifetch_req,
  input  logic [29:0] ifetch_addr,
  input  logic        ifetch_flush,
  output logic        ifetch_ready,
  output logic [31:0] ifetch_rdata,
  input  logic        dmem_req,
  input  logic        dmem_we,
  input  logic [29:0] dmem_addr,
  input  logic [31:0] dmem_wdata,
  input  logic [3:0]  dmem_be,
  output logic        dmem_ready,
  output logic [31:0] dmem_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [29:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        bus_error,
  output logic        busy,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_IFETCH_WAIT = 2'd1,
    ST_DATA_WAIT   = 2'd2,
    ST_RESP        = 2'd3
  } state_t;

  localparam logic [3:0]  STREAK_MAX   = 4'(MAX_DATA_STREAK);
  // The counter holds the number of completed WAIT cycles, so the last allowed
  // WAIT cycle is the one where it reads TIMEOUT_CYCLES-1.
  localparam logic [7:0]  TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] NOP_INSN     = 32'h0000_0013;

  state_t      state_q, state_d;
  logic [3:0]  streak_q;
  logic [7:0]  tmo_q;
  logic        discard_q;
  logic        resp_data_q;   // 1 when the transaction in flight belongs to data
  logic        grant_data, grant_fetch;
  logic        wait_ack, wait_tmo;
  logic        in_wait;

  assign in_wait = (state_q == ST_IFETCH_WAIT) || (state_q == ST_DATA_WAIT);

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    grant_data  = 1'b0;
    grant_fetch = 1'b0;
    wait_ack    = 1'b0;
    wait_tmo    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Data wins unless fetch is waiting and its patience has run out.
        if (dmem_req && !(ifetch_req && (streak_q == STREAK_MAX))) begin
          grant_data = 1'b1;
          state_d    = ST_DATA_WAIT;
        end else if (ifetch_req) begin
          grant_fetch = 1'b1;
          state_d     = ST_IFETCH_WAIT;
        end
      end
      ST_IFETCH_WAIT, ST_DATA_WAIT: begin
        if (mem_ack) begin
          wait_ack = 1'b1;
          state_d  = ST_RESP;
        end else if (tmo_q == TIMEOUT_LAST) begin
          wait_tmo = 1'b1;
          state_d  = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy       = (state_q != ST_IDLE);
  assign dbg_state  = state_q;
  assign dmem_ready = (state_q == ST_RESP) && resp_data_q;
  // A flush in the response cycle itself also kills the delivery.
  assign ifetch_ready = (state_q == ST_RESP) && !resp_data_q && !discard_q && !ifetch_flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_be       <= '0;
      ifetch_rdata <= '0;
      dmem_rdata   <= '0;
      bus_error    <= 1'b0;
      streak_q     <= '0;
      tmo_q        <= '0;
      discard_q    <= 1'b0;
      resp_data_q  <= 1'b0;
    end else begin
      if (grant_data) begin
        mem_req     <= 1'b1;
        mem_we      <= dmem_we;
        mem_addr    <= dmem_addr;
        mem_wdata   <= dmem_wdata;
        mem_be      <= dmem_we ? dmem_be : 4'hF;
        resp_data_q <= 1'b1;
        // Only grants that made fetch wait count toward the streak.
        if (ifetch_req) begin
          if (streak_q != STREAK_MAX) streak_q <= streak_q + 4'd1;
        end else begin
          streak_q <= '0;
        end
      end
      if (grant_fetch) begin
        mem_req     <= 1'b1;
        mem_we      <= 1'b0;
        mem_addr    <= ifetch_addr;
        mem_wdata   <= '0;
        mem_be      <= 4'hF;
        resp_data_q <= 1'b0;
        streak_q    <= '0;
      end
      if (in_wait) tmo_q <= tmo_q + 8'd1;
      if (wait_ack || wait_tmo) begin
        mem_req <= 1'b0;
        mem_we  <= 1'b0;
        tmo_q   <= '0;
      end
      if (wait_tmo) bus_error <= 1'b1;
      if ((state_q == ST_DATA_WAIT) && (wait_ack || wait_tmo))
        dmem_rdata <= (wait_ack && !mem_we) ? mem_rdata : 32'h0;
      if ((state_q == ST_IFETCH_WAIT) && (wait_ack || wait_tmo))
        ifetch_rdata <= wait_ack ? mem_rdata : NOP_INSN;
      // The memory access still completes; only the delivery is dropped.
      if ((state_q == ST_IFETCH_WAIT) && ifetch_flush) discard_q <= 1'b1;
      if (state_q == ST_RESP) discard_q <= 1'b0;
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified instruction/data memory between the fetch stage (instruction reads) and the memory stage (loads/stores).
- Sits between those two stages and the external memory port. Runs one memory transaction at a time under a 4-state FSM.
- Data side has priority, with an anti-starvation streak limit for fetch.
- Handles fetch flush on taken branch and a memory-ack timeout.

Parameters:
- MAX_DATA_STREAK, 4: consecutive data grants allowed while fetch waits before fetch is forced a grant (1..15).
- TIMEOUT_CYCLES, 64: cycles in a WAIT state without mem_ack before the transaction is abandoned (2..255).

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- ifetch_req  in  1  fetch requests an instruction word; held until ifetch_ready
- ifetch_addr  in  30  word address of the instruction
- ifetch_flush  in  1  pulse; the fetch in flight is stale (taken branch)
- ifetch_ready  out  1  one-cycle pulse; ifetch_rdata valid
- ifetch_rdata  out  32  instruction word
- dmem_req  in  1  memory stage request; held until dmem_ready
- dmem_we  in  1  1 = store, 0 = load
- dmem_addr  in  30  word address
- dmem_wdata  in  32  store data
- dmem_be  in  4  store byte enables
- dmem_ready  out  1  one-cycle pulse; transaction done
- dmem_rdata  out  32  load data; 0 for stores
- mem_req  out  1  request to memory; held until mem_ack
- mem_we  out  1  write strobe
- mem_addr  out  30  word address
- mem_wdata  out  32  write data
- mem_be  out  4  byte enables; 4'hF on reads
- mem_ack  in  1  memory completes the current request this cycle
- mem_rdata  in  32  read data, valid with mem_ack
- bus_error  out  1  sticky; a timeout occurred
- busy  out  1  FSM not in IDLE

Behaviour:
- Reset (synchronous, active-high) values:
  - state = IDLE.
  - mem_req, mem_we, ifetch_ready, dmem_ready, bus_error, busy = 0.
  - mem_addr, mem_wdata, ifetch_rdata, dmem_rdata = 0; mem_be = 0.
  - Streak counter, timeout counter and discard flag = 0.
- Reset mid-transaction abandons it; mem_req is 0 from the first cycle after the reset edge.
- FSM states: IDLE, IFETCH_WAIT, DATA_WAIT, RESP.
- IDLE arbitration (requests sampled each cycle):
  - Only dmem_req: grant data.
  - Only ifetch_req: grant fetch.
  - Both: grant data, unless streak == MAX_DATA_STREAK, then grant fetch.
  - Neither: stay in IDLE.
- On a grant, the mem_* outputs are registered from the winner's inputs at the edge, and the FSM goes to the matching WAIT state.
- Streak counter:
  - Increments on a data grant taken while ifetch_req = 1.
  - Clears on a fetch grant, or on a data grant taken with ifetch_req = 0.
  - Saturates at MAX_DATA_STREAK.
- WAIT states:
  - mem_req = 1 with all mem_* outputs stable.
  - The timeout counter increments every cycle.
  - On mem_ack: capture mem_rdata (forced to 0 for a store), drop mem_req, clear the timeout counter, go to RESP.
- RESP lasts exactly one cycle:
  - Pulses the winner's ready with the captured data. A data grant pulses dmem_ready.
  - A fetch grant pulses ifetch_ready only if discard = 0 and ifetch_flush = 0 this cycle.
  - Next state is IDLE. Requests are not arbitrated in RESP.
- Latency:
  - Request seen in IDLE at cycle N: mem_req at N+1. Best case mem_ack at N+1 gives ready at N+2.
  - The next grant is possible at N+3.
- Flush:
  - ifetch_flush in IFETCH_WAIT sets discard. The memory transaction still completes, but ifetch_ready is suppressed.
  - discard clears on entering IDLE.
  - Flush in IDLE or DATA_WAIT has no effect.
  - After a flush, fetch re-requests with the new address.
- Timeout:
  - When the timeout counter reaches TIMEOUT_CYCLES in a WAIT state: drop mem_req, set bus_error, go to RESP.
  - The captured data is 32'h00000013 (NOP) for fetch and 0 for data, so the pipeline never hangs.
  - bus_error clears only on rst.
- mem_ack outside the WAIT states is ignored.
- Requester inputs must stay stable while req = 1 until ready. Changes during WAIT are not observed.
- busy = 1 in IFETCH_WAIT, DATA_WAIT and RESP.

Test Plan:
- Fetch only, ifetch_addr = 30'h10, memory acks one cycle after mem_req with 32'h00500093 -> mem_req=1, mem_we=0, mem_addr=30'h10, mem_be=4'hF; ifetch_ready pulses once with 32'h00500093; busy returns to 0.
- Simultaneous ifetch_req and dmem_req store (addr 30'h20, wdata 32'hDEADBEEF, be 4'h3) -> data granted first (mem_we=1, mem_be=4'h3); dmem_rdata=0 on dmem_ready; fetch granted next, 3 cycles after the data grant.
- Both requests held continuously, MAX_DATA_STREAK = 4 -> grant order D,D,D,D,F,D,D,D,D,F.
- Fetch in flight, ifetch_flush pulsed 2 cycles before mem_ack -> no ifetch_ready pulse; FSM returns to IDLE; the next fetch with a new address completes normally.
- Load with mem_ack never asserted, TIMEOUT_CYCLES = 8 -> mem_req drops after 8 WAIT cycles; dmem_ready pulses with dmem_rdata=0; bus_error=1 and stays 1 until rst.
- rst asserted during DATA_WAIT -> from the next cycle mem_req=0, all ready=0, bus_error=0, busy=0; a new fetch request then completes normally.
